// File: rtl/snake_tick_timer_pkg.sv
// Shared constants and state encoding for the snake game tick timer.
package snake_tick_timer_pkg;

    localparam int TIMER_WIDTH     = 20;
    localparam int TIMER_CNT_WIDTH = 16;

    localparam logic [TIMER_WIDTH-1:0] TIMER_DEFAULT_PERIOD = 20'd781250;
    localparam logic [TIMER_WIDTH-1:0] TIMER_MIN_PERIOD     = 20'd16;

    localparam logic [TIMER_CNT_WIDTH-1:0] TIMER_CNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_PAUSED = 2'b10
    } state_t;

endpackage

// File: rtl/tick_elapsed_sub.sv
// Modular subtractor: a - b wrapped to WIDTH bits, so a timestamp that has
// rolled over past zero still yields the correct distance.
module tick_elapsed_sub
    import snake_tick_timer_pkg::*;
#(
    parameter int WIDTH = TIMER_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff
);

    // Borrow out of the top bit is simply dropped.
    assign diff = a - b;

endmodule

// File: rtl/snake_tick_timer.sv
// Game-step tick generator. A free-running timestamp (now) is compared with
// the timestamp of the last tick (last); pausing freezes the elapsed value
// and resuming rebases last so the paused cycles are not counted.
module snake_tick_timer
    import snake_tick_timer_pkg::*;
#(
    parameter int               WIDTH          = TIMER_WIDTH,
    parameter logic [WIDTH-1:0] DEFAULT_PERIOD = TIMER_DEFAULT_PERIOD,
    parameter logic [WIDTH-1:0] MIN_PERIOD     = TIMER_MIN_PERIOD
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       START,
    input  logic                       PAUSE,
    input  logic                       PERIOD_LD,
    input  logic [WIDTH-1:0]           PERIOD_IN,
    output logic                       TICK,
    output logic [TIMER_CNT_WIDTH-1:0] TICK_CNT,
    output logic [WIDTH-1:0]           ELAPSED,
    output logic [1:0]                 STATE
);

    state_t state_q;
    state_t state_next;

    logic [WIDTH-1:0] now_q;
    logic [WIDTH-1:0] last_q;
    logic [WIDTH-1:0] froz_q;
    logic [WIDTH-1:0] period_q;
    logic [WIDTH-1:0] run_elapsed;
    logic [WIDTH-1:0] resume_last;

    logic                       tick_q;
    logic [TIMER_CNT_WIDTH-1:0] tick_cnt_q;

    logic restart;
    logic tick_fire;
    logic pause_enter;
    logic resume;

    // Cycles since the last tick (or since start/resume rebase).
    tick_elapsed_sub #(.WIDTH(WIDTH)) u_run_sub (
        .a    (now_q),
        .b    (last_q),
        .diff (run_elapsed)
    );

    // On resume, last is moved back by the frozen amount so elapsed carries on.
    tick_elapsed_sub #(.WIDTH(WIDTH)) u_resume_sub (
        .a    (now_q),
        .b    (froz_q),
        .diff (resume_last)
    );

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // Next-state and control strobes; START wins over PAUSE in every state.
    always_comb begin
        state_next  = state_q;
        restart     = 1'b0;
        tick_fire   = 1'b0;
        pause_enter = 1'b0;
        resume      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_next = ST_RUN;
                    restart    = 1'b1;
                end
            end
            ST_RUN: begin
                if (START) begin
                    restart = 1'b1;
                end else if (PAUSE) begin
                    state_next  = ST_PAUSED;
                    pause_enter = 1'b1;
                end else if (run_elapsed >= period_q) begin
                    tick_fire = 1'b1;
                end
            end
            ST_PAUSED: begin
                if (START) begin
                    state_next = ST_RUN;
                    restart    = 1'b1;
                end else if (!PAUSE) begin
                    state_next = ST_RUN;
                    resume     = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Free-running timestamp, wraps naturally at the top of its range.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            now_q <= '0;
        end else begin
            now_q <= now_q + WIDTH'(1);
        end
    end

    // Period register; too-short requests are raised to the minimum.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            period_q <= DEFAULT_PERIOD;
        end else if (PERIOD_LD) begin
            period_q <= (PERIOD_IN < MIN_PERIOD) ? MIN_PERIOD : PERIOD_IN;
        end
    end

    // Reference timestamp and frozen elapsed value for pause handling.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_q <= '0;
            froz_q <= '0;
        end else begin
            if (restart || tick_fire) begin
                last_q <= now_q;
            end else if (resume) begin
                last_q <= resume_last;
            end
            if (pause_enter) begin
                froz_q <= run_elapsed;
            end
        end
    end

    // Registered tick pulse and saturating tick counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tick_q     <= 1'b0;
            tick_cnt_q <= '0;
        end else begin
            tick_q <= tick_fire;
            if (restart) begin
                tick_cnt_q <= '0;
            end else if (tick_fire && (tick_cnt_q != TIMER_CNT_MAX)) begin
                tick_cnt_q <= tick_cnt_q + TIMER_CNT_WIDTH'(1);
            end
        end
    end

    // Visible elapsed time depends only on registered state.
    always_comb begin
        ELAPSED = '0;
        case (state_q)
            ST_RUN:    ELAPSED = run_elapsed;
            ST_PAUSED: ELAPSED = froz_q;
            default:   ELAPSED = '0;
        endcase
    end

    assign TICK     = tick_q;
    assign TICK_CNT = tick_cnt_q;
    assign STATE    = state_q;

endmodule

// File: tb/tb_snake_tick_timer.sv
// Scoreboard bench for snake_tick_timer: stimulus queues expected ticks and
// state snapshots by cycle number; a negedge monitor pops and compares.
module tb_snake_tick_timer;
    import snake_tick_timer_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic        PAUSE;
    logic        PERIOD_LD;
    logic [19:0] PERIOD_IN;
    logic        TICK;
    logic [15:0] TICK_CNT;
    logic [19:0] ELAPSED;
    logic [1:0]  STATE;

    snake_tick_timer dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .PAUSE     (PAUSE),
        .PERIOD_LD (PERIOD_LD),
        .PERIOD_IN (PERIOD_IN),
        .TICK      (TICK),
        .TICK_CNT  (TICK_CNT),
        .ELAPSED   (ELAPSED),
        .STATE     (STATE)
    );

    // 10-unit clock period.
    always #5 CLK = ~CLK;

    typedef struct {
        int          cyc;
        logic [15:0] cnt;
    } tick_exp_t;

    typedef struct {
        int          cyc;
        int          tag;
        logic [1:0]  state;
        logic [19:0] elapsed;
        logic [15:0] cnt;
    } probe_t;

    tick_exp_t tick_q[$];
    probe_t    probe_q[$];
    tick_exp_t mon_tick;
    probe_t    mon_probe;

    int cyc       = 0;
    int checks    = 0;
    int fails     = 0;
    int probe_tag = 0;
    bit win_on    = 1'b0;
    int win_max   = 0;

    // Cycle index: the value seen between posedge N and posedge N+1 is N.
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic report_fail(input string name);
        checks++;
        fails++;
        $display("[TB] FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitor: checks every TICK against the expected queue and compares
    // snapshots whose cycle has arrived.
    always @(negedge CLK) begin
        while (tick_q.size() > 0 && tick_q[0].cyc < cyc) begin
            mon_tick = tick_q.pop_front();
            report_fail($sformatf("tick_missing expected at cycle %0d cnt %0d", mon_tick.cyc, mon_tick.cnt));
        end
        if (TICK === 1'b1) begin
            if (tick_q.size() == 0) begin
                report_fail("tick_unexpected");
            end else begin
                mon_tick = tick_q.pop_front();
                check_output("tick_cycle", cyc, mon_tick.cyc);
                check_output("tick_cnt", {16'd0, TICK_CNT}, {16'd0, mon_tick.cnt});
            end
        end
        while (probe_q.size() > 0 && probe_q[0].cyc <= cyc) begin
            mon_probe = probe_q.pop_front();
            if (mon_probe.cyc != cyc) begin
                report_fail($sformatf("probe%0d_skipped", mon_probe.tag));
            end else begin
                check_output($sformatf("probe%0d_state", mon_probe.tag), {30'd0, STATE}, {30'd0, mon_probe.state});
                check_output($sformatf("probe%0d_elapsed", mon_probe.tag), {12'd0, ELAPSED}, {12'd0, mon_probe.elapsed});
                check_output($sformatf("probe%0d_tick_cnt", mon_probe.tag), {16'd0, TICK_CNT}, {16'd0, mon_probe.cnt});
            end
        end
        if (win_on && STATE == ST_RUN && int'(ELAPSED) > win_max) begin
            win_max = int'(ELAPSED);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic goto_cycle(input int c);
        while (cyc < c) step(1);
    endtask

    task automatic push_tick(input int c, input logic [15:0] n);
        tick_exp_t t;
        t.cyc = c;
        t.cnt = n;
        tick_q.push_back(t);
    endtask

    task automatic push_probe(input int c, input logic [1:0] s,
                              input logic [19:0] e, input logic [15:0] n);
        probe_t p;
        p.cyc     = c;
        p.tag     = probe_tag;
        p.state   = s;
        p.elapsed = e;
        p.cnt     = n;
        probe_tag++;
        probe_q.push_back(p);
    endtask

    task automatic apply_stimulus(input logic start, input logic pause,
                                  input logic ld, input logic [19:0] pin);
        START     = start;
        PAUSE     = pause;
        PERIOD_LD = ld;
        PERIOD_IN = pin;
    endtask

    int cr, s1, t1, s2, t5, s4, s5, x6;

    initial begin
        RST = 1'b1;
        apply_stimulus(1'b0, 1'b0, 1'b0, 20'd0);
        push_probe(2, ST_IDLE, 20'd0, 16'd0);
        step(3);
        RST = 1'b0;
        cr  = cyc;
        push_probe(cr, ST_IDLE, 20'd0, 16'd0);

        // Default period: first tick 781251 cycles after the START cycle.
        step(1);
        s1 = cyc;
        apply_stimulus(1'b1, 1'b0, 1'b0, 20'd0);
        push_probe(s1 + 1, ST_RUN, 20'd1, 16'd0);
        push_probe(s1 + 1000, ST_RUN, 20'd1000, 16'd0);
        t1 = s1 + 781251;
        push_tick(t1, 16'd1);
        step(1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 20'd0);
        goto_cycle(t1);

        // Period 100 then restart: five ticks 100 cycles apart.
        step(1);
        apply_stimulus(1'b0, 1'b0, 1'b1, 20'd100);
        step(1);
        s2 = cyc;
        apply_stimulus(1'b1, 1'b0, 1'b0, 20'd100);
        for (int k = 0; k < 5; k++) push_tick(s2 + 101 + 100 * k, 16'(k + 1));
        t5 = s2 + 101 + 400;
        step(1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 20'd0);
        goto_cycle(t5);

        // Load 3 right after the fifth tick: clamps to 16.
        step(1);
        apply_stimulus(1'b0, 1'b0, 1'b1, 20'd3);
        for (int k = 1; k <= 3; k++) push_tick(t5 + 16 * k, 16'(5 + k));
        step(1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 20'd0);
        goto_cycle(t5 + 48);

        // Period 100 with restart, pause at elapsed 40 for 500 cycles.
        step(1);
        s4 = cyc;
        apply_stimulus(1'b1, 1'b0, 1'b1, 20'd100);
        push_probe(s4 + 40, ST_RUN, 20'd40, 16'd0);
        push_probe(s4 + 41, ST_PAUSED, 20'd40, 16'd0);
        push_probe(s4 + 300, ST_PAUSED, 20'd40, 16'd0);
        push_probe(s4 + 540, ST_PAUSED, 20'd40, 16'd0);
        push_probe(s4 + 541, ST_RUN, 20'd41, 16'd0);
        push_probe(s4 + 600, ST_RUN, 20'd100, 16'd0);
        push_tick(s4 + 601, 16'd1);
        push_probe(s4 + 700, ST_PAUSED, 20'd2, 16'd1);
        step(1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 20'd0);
        goto_cycle(s4 + 40);
        PAUSE = 1'b1;
        goto_cycle(s4 + 540);
        PAUSE = 1'b0;
        goto_cycle(s4 + 602);
        PAUSE = 1'b1;

        // Restart with now = 0xFFFF0 so the timestamp wraps mid-period.
        s5 = cr + 32'h000FFFF0;
        push_probe(s5, ST_PAUSED, 20'd2, 16'd1);
        push_probe(s5 + 16, ST_RUN, 20'd16, 16'd0);
        push_probe(s5 + 100, ST_RUN, 20'd100, 16'd0);
        push_probe(s5 + 101, ST_RUN, 20'd1, 16'd1);
        push_tick(s5 + 101, 16'd1);
        push_tick(s5 + 201, 16'd2);
        goto_cycle(s5);
        apply_stimulus(1'b1, 1'b0, 1'b0, 20'd0);
        step(1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 20'd0);
        win_max = 0;
        win_on  = 1'b1;
        goto_cycle(s5 + 202);
        win_on = 1'b0;
        check_output("wrap_max_elapsed", win_max, 100);

        // Reset mid-run, then START and PAUSE together.
        goto_cycle(s5 + 250);
        RST = 1'b1;
        push_probe(s5 + 250, ST_IDLE, 20'd0, 16'd0);
        push_probe(s5 + 252, ST_IDLE, 20'd0, 16'd0);
        step(2);
        RST = 1'b0;
        step(1);
        x6 = cyc;
        apply_stimulus(1'b1, 1'b1, 1'b0, 20'd0);
        push_probe(x6 + 1, ST_RUN, 20'd1, 16'd0);
        push_probe(x6 + 2, ST_PAUSED, 20'd1, 16'd0);
        push_probe(x6 + 150, ST_PAUSED, 20'd1, 16'd0);
        step(1);
        START = 1'b0;
        goto_cycle(x6 + 160);

        check_output("pending_ticks", tick_q.size(), 0);
        check_output("pending_probes", probe_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/snake_tick_timer.md
SNAKE_TICK_TIMER -- requirements
Module: snake_tick_timer

Interface
REQ-001 Parameters SHALL be, one per line:
- WIDTH, 20, width of timestamp, period and elapsed values.
- DEFAULT_PERIOD, 20'd781250, tick period after reset, in CLK cycles.
- MIN_PERIOD, 20'd16, smallest accepted period; smaller loads clamp to this.

REQ-002 Ports SHALL be, one per line:
- CLK  in  1  sole clock; all state on rising edge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  pulse; begin or restart the tick sequence.
- PAUSE  in  1  level; 1 = freeze elapsed time.
- PERIOD_LD  in  1  pulse; load PERIOD_IN.
- PERIOD_IN  in  20  new tick period, in cycles.
- TICK  out  1  one-cycle game-step pulse.
- TICK_CNT  out  16  ticks since last START, saturating.
- ELAPSED  out  20  cycles elapsed in the current period.
- STATE  out  2  00 IDLE, 01 RUN, 10 PAUSED.

REQ-003 One clock; reset asynchronous, active-high.

Function
REQ-004 NOW SHALL be a 20-bit free-running counter:
- +1 every cycle in all states.
- wraps 20'hFFFFF -> 0.

REQ-005 ELAPSED SHALL be combinational from registers only:
- RUN: (NOW - LAST) mod 2^20.
- PAUSED: FROZ.
- IDLE: 0.
- Wrap of NOW is correct by modular arithmetic; no special case.

REQ-006 PERIOD register SHALL load PERIOD_IN on PERIOD_LD, clamped to MIN_PERIOD when smaller. The new value governs the comparison from the next cycle.

REQ-007 In RUN, when ELAPSED >= PERIOD, on that edge:
- LAST <= NOW.
- TICK <= 1 (registered; visible in the following cycle).
- TICK_CNT <= TICK_CNT + 1, saturating at 16'hFFFF.

REQ-008 With constant PERIOD and no pause, consecutive TICK pulses SHALL be exactly PERIOD cycles apart. The first TICK SHALL be PERIOD+1 cycles after the START cycle.

REQ-009 TICK SHALL be high for exactly one cycle per tick, and never in IDLE or PAUSED, except the registered pulse from the RUN cycle immediately before the transition.

REQ-010 FSM transitions (START has priority over PAUSE):
- IDLE -> RUN on START: LAST <= NOW, TICK_CNT <= 0.
- RUN -> RUN on START (restart): LAST <= NOW, TICK_CNT <= 0.
- PAUSED -> RUN on START (restart): LAST <= NOW, TICK_CNT <= 0.
- RUN -> PAUSED on PAUSE=1 and no START: FROZ <= current ELAPSED; no tick evaluation that cycle.
- PAUSED -> RUN on PAUSE=0: LAST <= NOW - FROZ. Elapsed resumes with paused cycles excluded.
- IDLE ignores PAUSE.

REQ-011 If START and PAUSE are both high, the block SHALL go to RUN; PAUSE is honoured from the next cycle.

REQ-012 If PERIOD_LD lowers PERIOD below the current ELAPSED in RUN, the tick SHALL fire on the next evaluation cycle. Only one tick fires; there is no catch-up burst.

REQ-013 If PERIOD_LD coincides with a tick condition, the tick SHALL be evaluated against the old PERIOD.

Reset
REQ-014 While RST=1, asynchronously:
- NOW = 0, LAST = 0, FROZ = 0.
- PERIOD = DEFAULT_PERIOD.
- STATE = IDLE.
- TICK = 0, TICK_CNT = 0.
- ELAPSED therefore reads 0.

REQ-015 Reset mid-RUN or mid-PAUSE SHALL abandon the sequence. No TICK SHALL appear until a new START.

Structure
REQ-016 A shared package SHALL hold:
- the state encoding constants (IDLE/RUN/PAUSED).
- WIDTH.
- DEFAULT_PERIOD and MIN_PERIOD.

REQ-017 One sub-module SHALL be used: tick_elapsed_sub, a 20-bit modular subtractor (A - B, carry-out discarded). It is instantiated for NOW - LAST and for NOW - FROZ.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Reset, START, PERIOD default -> first TICK 781251 cycles after START; TICK_CNT = 1.
- PERIOD_LD 100, START -> TICKs every 100 cycles; TICK_CNT = 5 after the 5th.
- PERIOD_LD 3 -> PERIOD clamps to 16; TICKs every 16 cycles.
- PERIOD 100, PAUSE at ELAPSED = 40 for 500 cycles -> ELAPSED holds 40; next TICK 60 cycles after resume.
- START with NOW = 20'hFFFF0, PERIOD 100 -> TICK exactly 100 cycles after the first tick despite wrap; ELAPSED never exceeds 100.
- RST asserted mid-RUN, START and PAUSE together after release -> STATE = RUN; PAUSED next cycle; TICK_CNT = 0.
